rom_port_arbiter: RTL and testbench
===================================

Name: rom_port_arbiter

Overview:
- Shares the single combinational instruction ROM between two requesters.
  - Port 0: CPU instruction fetch.
  - Port 1: debug/UART memory-dump reader.
- Presents one word address per cycle to the ROM and registers the returned word.
- Returns the registered word to the granted requester one cycle later.
- Fixed priority to port 0, with a starvation guard so port 1 always eventually completes.

Parameters:
- ADDR_W, 8: word-index width driven to the ROM (byte address bits [ADDR_W+1:2]).
- MAX_WAIT, 4: consecutive cycles port 1 may be denied before it is force-granted; legal range 1..15.
- OOR_DATA, 32'h00000000: word returned for out-of-range addresses.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- req0, input, 1: port 0 request.
- addr0, input, 32: port 0 byte address.
- gnt0, output, 1: port 0 request accepted this cycle (combinational).
- rvalid0, output, 1: port 0 read data valid.
- rdata0, output, 32: port 0 read data.
- req1, input, 1: port 1 request.
- addr1, input, 32: port 1 byte address.
- gnt1, output, 1: port 1 request accepted this cycle (combinational).
- rvalid1, output, 1: port 1 read data valid.
- rdata1, output, 32: port 1 read data.
- oor1, output, 1: qualifies rvalid1; the accepted port 1 address was out of range.
- rom_addr, output, 32: byte address to the ROM; bits [1:0] are forced to 0.
- rom_data, input, 32: combinational ROM word.

Behaviour:
- Reset (synchronous, active-high): rvalid0/1=0, rdata0/1=0, oor1=0, starve counter=0, state=NORMAL. A pending response is discarded and not delivered after reset deasserts.
- Handshake:
  - A requester holds req and a stable addr until it sees gnt in the same cycle.
  - The cycle with req&gnt is the accept cycle.
  - rvalid pulses for exactly 1 cycle in the cycle after accept (latency 1).
  - Back-to-back accepts on consecutive cycles are allowed; throughput is 1 word/cycle total.
- At most one of gnt0/gnt1 is high in any cycle. gnt is never asserted without the matching req.
- rom_addr = {addr_sel[31:2], 2'b00}, where addr_sel is the address of the granted port.
  - With no grant, rom_addr = addr0 (aligned), so idle fetch timing is unchanged.
- rdata register captures rom_data at the accept edge. Only the granted port's rvalid rises. rdata of the other port holds its previous value.
- Alignment: byte offset addr[1:0] is ignored silently (word access only).
- Out of range: addr[31:ADDR_W+2] != 0.
  - Port 0: returns OOR_DATA with rvalid0.
  - Port 1: returns OOR_DATA with rvalid1 and oor1=1.
- State machine, states NORMAL and FORCE1:
  - NORMAL:
    - If req0, grant 0. If additionally req1, starve counter +1.
    - Otherwise, if req1, grant 1 and clear the counter.
    - If the counter reaches MAX_WAIT while req1 is still high, go to FORCE1 on the next edge.
  - FORCE1:
    - If req1, grant 1 regardless of req0, clear the counter, return to NORMAL.
    - If req1 has dropped (protocol violation), return to NORMAL with the counter cleared.
  - The counter clears whenever req1=0. It saturates and never wraps; width is 4 bits.
- Simultaneous req0 & req1 in NORMAL with counter < MAX_WAIT: port 0 wins, gnt1=0.
- Reset asserted in the same cycle as an accept: the accept is ignored and no rvalid follows.

Decomposition:
- Shared package (rom_arb_pkg):
  - state encoding localparams ST_NORMAL=1'b0 and ST_FORCE1=1'b1.
  - port index constants PORT_FETCH=0 and PORT_DBG=1.
  - width constant WORD_W=32.
- One natural sub-module, rom_arb_starve_cnt: the saturating 4-bit counter with inc/clr/hit(MAX_WAIT) outputs.
- Grant logic, address mux and response registers stay in the top module.

Test Plan (bench ROM model: rom_data = ~rom_addr):
- Reset: hold reset 3 cycles with req0=req1=1 -> no rvalid during reset or in the cycle after it; all outputs 0 while reset is high.
- Port 0 only: req0=1, addr0 stepping 0x0,0x4,0x8 -> gnt0=1 each cycle; rvalid0 one cycle later with rdata0=0xFFFFFFFF, 0xFFFFFFFB, 0xFFFFFFF7.
- Contention, MAX_WAIT=4: req0 and req1 held continuously, addr1=0x40 -> gnt0 for cycles 1-4, gnt1 in cycle 5; rvalid1 in cycle 6 with rdata1=0xFFFFFFBF; then port 0 resumes.
- Port 1 idle-slot: req1=1 with req0 low, addr1=0x1C -> gnt1 the same cycle; rvalid1 next cycle with rdata1=0xFFFFFFE3, oor1=0; counter stays 0.
- Out of range, ADDR_W=8: addr1=0x400 -> gnt1, then rvalid1=1, oor1=1, rdata1=0x00000000. Misaligned addr0=0x7 -> rom_addr=0x4.
- Reset mid-operation: accept on port 1 at cycle N with reset=1 at edge N+1 -> rvalid1 stays 0 and the counter is 0 afterwards.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared constants and helpers for the instruction-ROM port arbiter.
// State encoding, port indices, word width and address helper functions.
package rom_arb_pkg;

    localparam int   WORD_W     = 32;
    localparam logic ST_NORMAL  = 1'b0;
    localparam logic ST_FORCE1  = 1'b1;
    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DBG   = 1'b1;

    typedef enum logic {
        S_NORMAL = ST_NORMAL,
        S_FORCE1 = ST_FORCE1
    } arb_state_e;

    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
        return {a[WORD_W-1:2], 2'b00};
    endfunction

    // True when any address bit above the ROM word index is set.
    function automatic logic addr_oor(input logic [WORD_W-1:0] a, input int addr_w);
        return (a >> (addr_w + 2)) != '0;
    endfunction

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Bundle of both requester handshakes plus the ROM address/data pair.
// The arbiter uses the slave modport; requesters and the ROM model sit on master.
interface rom_port_arbiter_if;
    import rom_arb_pkg::*;

    logic              req0;
    logic [WORD_W-1:0] addr0;
    logic              gnt0;
    logic              rvalid0;
    logic [WORD_W-1:0] rdata0;

    logic              req1;
    logic [WORD_W-1:0] addr1;
    logic              gnt1;
    logic              rvalid1;
    logic [WORD_W-1:0] rdata1;
    logic              oor1;

    logic [WORD_W-1:0] rom_addr;
    logic [WORD_W-1:0] rom_data;

    modport slave (
        input  req0, addr0, req1, addr1, rom_data,
        output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, oor1, rom_addr
    );

    modport master (
        output req0, addr0, req1, addr1, rom_data,
        input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, oor1, rom_addr
    );

endinterface

// File: rtl/rom_arb_starve_cnt.sv
// Saturating 4-bit count of consecutive cycles the debug port was denied.
// hit_next flags that the pending increment brings the count to MAX_WAIT.
module rom_arb_starve_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic hit,
    output logic hit_next
);

    localparam logic [3:0] LIMIT = 4'(MAX_WAIT);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= 4'd0;
        end else if (inc && cnt != 4'hF) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign hit      = cnt >= LIMIT;
    assign hit_next = inc && !clr && (cnt >= LIMIT - 4'd1);

endmodule

// File: rtl/rom_port_arbiter.sv
// Two-port arbiter in front of the combinational instruction ROM.
// Fixed priority to fetch (port 0) with a starvation guard for the debug reader.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_NORMAL | fetch wins; debug served in idle slots, denials counted
//   S_FORCE1 | debug denied MAX_WAIT cycles: grant it this cycle
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                MAX_WAIT = 4,
    parameter logic [WORD_W-1:0] OOR_DATA = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           reset,
    rom_port_arbiter_if.slave bus
);

    arb_state_e state;
    arb_state_e state_next;

    logic g0;
    logic g1;
    logic cnt_inc;
    logic cnt_clr;
    logic cnt_hit;
    logic cnt_hit_next;
    logic sel_port;
    logic oor0;
    logic oor1_a;

    rom_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (cnt_inc),
        .clr      (cnt_clr),
        .hit      (cnt_hit),
        .hit_next (cnt_hit_next)
    );

    // Grants are suppressed while reset is high so no accept can occur.
    always_comb begin
        state_next = state;
        g0         = 1'b0;
        g1         = 1'b0;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        if (!reset) begin
            case (state)
                S_NORMAL: begin
                    if (bus.req0) begin
                        g0 = 1'b1;
                        if (bus.req1) begin
                            cnt_inc = 1'b1;
                            if (cnt_hit_next || cnt_hit) begin
                                state_next = S_FORCE1;
                            end
                        end else begin
                            cnt_clr = 1'b1;
                        end
                    end else if (bus.req1) begin
                        g1      = 1'b1;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_clr = 1'b1;
                    end
                end
                S_FORCE1: begin
                    cnt_clr    = 1'b1;
                    state_next = S_NORMAL;
                    if (bus.req1) begin
                        g1 = 1'b1;
                    end else if (bus.req0) begin
                        g0 = 1'b1;
                    end
                end
                default: begin
                    state_next = S_NORMAL;
                    cnt_clr    = 1'b1;
                end
            endcase
        end
    end

    assign sel_port = g1 ? PORT_DBG : PORT_FETCH;
    assign oor0     = addr_oor(bus.addr0, ADDR_W);
    assign oor1_a   = addr_oor(bus.addr1, ADDR_W);

    assign bus.gnt0     = g0;
    assign bus.gnt1     = g1;
    assign bus.rom_addr = (sel_port == PORT_DBG) ? word_align(bus.addr1)
                                                 : word_align(bus.addr0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_NORMAL;
            bus.rvalid0 <= 1'b0;
            bus.rdata0  <= '0;
            bus.rvalid1 <= 1'b0;
            bus.rdata1  <= '0;
            bus.oor1    <= 1'b0;
        end else begin
            state       <= state_next;
            bus.rvalid0 <= g0;
            bus.rvalid1 <= g1;
            bus.oor1    <= g1 && oor1_a;
            if (g0) begin
                bus.rdata0 <= oor0 ? OOR_DATA : bus.rom_data;
            end
            if (g1) begin
                bus.rdata1 <= oor1_a ? OOR_DATA : bus.rom_data;
            end
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: vector table, hand-written corner sequences,
// and randomized protocol-abiding traffic against a reference model.
module tb_rom_port_arbiter;

    localparam int MAX_WAIT = 4;

    logic clk;
    logic reset;

    rom_port_arbiter_if bus ();

    rom_port_arbiter #(
        .ADDR_W   (8),
        .MAX_WAIT (MAX_WAIT),
        .OOR_DATA (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    assign bus.rom_data = ~bus.rom_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: counts consecutive denials of a waiting port-1 request.
    int          m_wait;
    bit          m_force;
    logic        m_rv0, m_rv1, m_oor1;
    logic [31:0] m_rd0, m_rd1;

    logic        last_g0, last_g1;
    logic [31:0] last_rom;

    typedef struct {
        logic        r0;
        logic [31:0] a0;
        logic        r1;
        logic [31:0] a1;
        logic        g0;
        logic        g1;
        logic [31:0] rom;
        logic        rv0;
        logic [31:0] rd0;
        logic        rv1;
        logic [31:0] rd1;
        logic        oor1;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic bit ref_oor(input logic [31:0] a);
        return a >= 32'h400;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return ref_oor(a) ? 32'h0 : ~(a & ~32'h3);
    endfunction

    task automatic step(input logic rs, input logic r0, input logic [31:0] a0,
                        input logic r1, input logic [31:0] a1);
        logic        e_g0, e_g1;
        logic [31:0] e_rom;
        @(negedge clk);
        reset     = rs;
        bus.req0  = r0;
        bus.addr0 = a0;
        bus.req1  = r1;
        bus.addr1 = a1;
        #1;
        e_g0 = 1'b0;
        e_g1 = 1'b0;
        if (!rs) begin
            if (m_force && r1)  e_g1 = 1'b1;
            else if (r0)        e_g0 = 1'b1;
            else if (r1)        e_g1 = 1'b1;
        end
        e_rom = e_g1 ? (a1 & ~32'h3) : (a0 & ~32'h3);
        chk("gnt0", bus.gnt0, e_g0);
        chk("gnt1", bus.gnt1, e_g1);
        chk("rom_addr", bus.rom_addr, e_rom);
        last_g0  = bus.gnt0;
        last_g1  = bus.gnt1;
        last_rom = bus.rom_addr;
        if (rs) begin
            m_wait  = 0;
            m_force = 0;
            m_rv0   = 0;
            m_rv1   = 0;
            m_rd0   = '0;
            m_rd1   = '0;
        end else begin
            m_rv0 = e_g0;
            m_rv1 = e_g1;
            if (e_g0) m_rd0 = ref_word(a0);
            if (e_g1) begin
                m_rd1  = ref_word(a1);
                m_oor1 = ref_oor(a1);
            end
            if (r1 && !e_g1) m_wait++;
            else             m_wait = 0;
            m_force = (m_wait >= MAX_WAIT);
        end
        @(posedge clk);
        #1;
        chk("rvalid0", bus.rvalid0, m_rv0);
        chk("rvalid1", bus.rvalid1, m_rv1);
        chk("rdata0", bus.rdata0, m_rd0);
        chk("rdata1", bus.rdata1, m_rd1);
        if (m_rv1) chk("oor1", bus.oor1, m_oor1);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return $urandom | 32'h400;
            default: return 32'($urandom_range(0, 1023));
        endcase
    endfunction

    initial begin
        bit          p0, p1;
        logic [31:0] ra0, ra1;
        int          cyc;

        reset = 1'b1;
        bus.req0 = 0; bus.addr0 = 0; bus.req1 = 0; bus.addr1 = 0;
        m_wait = 0; m_force = 0; m_rv0 = 0; m_rv1 = 0; m_oor1 = 0;
        m_rd0 = 0; m_rd1 = 0;

        // Reset held with both requests up: nothing granted, outputs stay 0.
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 32'h0, 1, 32'h40);
            chk("rst_oor1", bus.oor1, 1'b0);
        end
        step(0, 0, 32'h0, 0, 32'h0);

        //            r0  a0            r1  a1            g0 g1 rom            rv0 rd0            rv1 rd1            oor1
        vecs[0] = '{1, 32'h0,    0, 32'h0,    1, 0, 32'h0,    1, 32'hFFFFFFFF, 0, 32'h0,        0};
        vecs[1] = '{1, 32'h4,    0, 32'h0,    1, 0, 32'h4,    1, 32'hFFFFFFFB, 0, 32'h0,        0};
        vecs[2] = '{1, 32'h8,    0, 32'h0,    1, 0, 32'h8,    1, 32'hFFFFFFF7, 0, 32'h0,        0};
        vecs[3] = '{0, 32'h0,    1, 32'h400,  0, 1, 32'h400,  0, 32'hFFFFFFF7, 1, 32'h0,        1};
        vecs[4] = '{0, 32'h0,    1, 32'h1C,   0, 1, 32'h1C,   0, 32'hFFFFFFF7, 1, 32'hFFFFFFE3, 0};
        vecs[5] = '{1, 32'h7,    0, 32'h0,    1, 0, 32'h4,    1, 32'hFFFFFFFB, 0, 32'hFFFFFFE3, 0};
        vecs[6] = '{1, 32'h1000, 0, 32'h0,    1, 0, 32'h1000, 1, 32'h0,        0, 32'hFFFFFFE3, 0};
        vecs[7] = '{0, 32'h10,   0, 32'h0,    0, 0, 32'h10,   0, 32'h0,        0, 32'hFFFFFFE3, 0};
        vecs[8] = '{1, 32'h20,   1, 32'h30,   1, 0, 32'h20,   1, 32'hFFFFFFDF, 0, 32'hFFFFFFE3, 0};
        vecs[9] = '{0, 32'h0,    1, 32'h30,   0, 1, 32'h30,   0, 32'hFFFFFFDF, 1, 32'hFFFFFFCF, 0};

        for (int i = 0; i < 10; i++) begin
            step(0, vecs[i].r0, vecs[i].a0, vecs[i].r1, vecs[i].a1);
            chk($sformatf("v%0d_gnt0", i), last_g0, vecs[i].g0);
            chk($sformatf("v%0d_gnt1", i), last_g1, vecs[i].g1);
            chk($sformatf("v%0d_rom", i), last_rom, vecs[i].rom);
            chk($sformatf("v%0d_rv0", i), bus.rvalid0, vecs[i].rv0);
            chk($sformatf("v%0d_rd0", i), bus.rdata0, vecs[i].rd0);
            chk($sformatf("v%0d_rv1", i), bus.rvalid1, vecs[i].rv1);
            chk($sformatf("v%0d_rd1", i), bus.rdata1, vecs[i].rd1);
            if (vecs[i].rv1) chk($sformatf("v%0d_oor1", i), bus.oor1, vecs[i].oor1);
        end

        // Contention: port 1 must be force-granted in the fifth cycle.
        p1 = 1;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 32'h100 + 32'(4 * i), p1, 32'h40);
            chk($sformatf("cont%0d_gnt1", i), last_g1, i == 4);
            chk($sformatf("cont%0d_gnt0", i), last_g0, i != 4);
            if (i == 4) begin
                chk("cont_rv1", bus.rvalid1, 1'b1);
                chk("cont_rd1", bus.rdata1, 32'hFFFFFFBF);
            end
            if (last_g1) p1 = 0;
        end

        // Build up starvation, reset with requests up, then expect a full wait again.
        for (int i = 0; i < 3; i++) step(0, 1, 32'h0, 1, 32'h80);
        step(1, 1, 32'h0, 1, 32'h80);
        chk("mid_rst_gnt1", last_g1, 1'b0);
        chk("mid_rst_rv1", bus.rvalid1, 1'b0);
        cyc = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 32'h0, 1, 32'h80);
            cyc++;
            if (last_g1) break;
        end
        chk("post_rst_wait", 32'(cyc), 32'd5);
        step(0, 0, 32'h0, 0, 32'h0);

        // Random protocol-abiding traffic with occasional resets.
        p0 = 0; p1 = 0; ra0 = 0; ra1 = 0;
        for (int i = 0; i < 400; i++) begin
            logic rs;
            if (!p0 && $urandom_range(0, 3) != 0) begin p0 = 1; ra0 = rand_addr(); end
            if (!p1 && $urandom_range(0, 2) == 0) begin p1 = 1; ra1 = rand_addr(); end
            rs = ($urandom_range(0, 63) == 0);
            step(rs, p0, ra0, p1, ra1);
            if (last_g0) p0 = 0;
            if (last_g1) p1 = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
